// File: rtl/serial_sub_4b_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand/counter widths.
package serial_sub_4b_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned DEFAULT_CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_sub_4b_if.sv
// Request/result bundle of the bit-serial subtractor.
// master: drives start/a/b/b_in, observes busy/done/diff/b_out/ovf/zero.
// slave:  the subtractor side of the same signals.
interface serial_sub_4b_if
  import serial_sub_4b_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b, b_in,
    input  busy, done, diff, b_out, ovf, zero
  );

  modport slave (
    input  start, a, b, b_in,
    output busy, done, diff, b_out, ovf, zero
  );

endinterface

// File: rtl/serial_sub_4b_fa.sv
// Structural one-bit full adder used as the serial arithmetic cell.
// Ports: a, b, c_in (addends and carry in); sum, c_out (results).
module FA_str (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  logic p;

  assign p     = a ^ b;
  assign sum   = p ^ c_in;
  assign c_out = (a & b) | (c_in & p);

endmodule

// File: rtl/serial_sub_4b.sv
// Bit-serial two's-complement subtractor: diff = a - b - b_in, LSB first,
// one bit per clock through a single full adder (a + ~b + ~b_in).
// Ports: clk, rst (synchronous, active high); bus (slave side of
// serial_sub_4b_if: start/a/b/b_in in, busy/done/diff/b_out/ovf/zero out).
module serial_sub_4b
  import serial_sub_4b_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input logic            clk,
  input logic            rst,
  serial_sub_4b_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] nb_sr_q, nb_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             b_out_q, b_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic accept;
  logic last_step;
  logic fa_sum;
  logic fa_cout;

  // Starts are only honoured when no operation is in flight.
  assign accept    = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_step = (state_q == S_RUN) && (cnt_q == CNT_W'(WIDTH - 1));

  FA_str u_fa (
    .a     (a_sr_q[0]),
    .b     (nb_sr_q[0]),
    .c_in  (carry_q),
    .sum   (fa_sum),
    .c_out (fa_cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (last_step) state_d = S_DONE;
      S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.busy = (state_q == S_RUN);
    bus.done = (state_q == S_DONE);
  end

  // Datapath next-state
  always_comb begin
    a_sr_d  = a_sr_q;
    nb_sr_d = nb_sr_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    b_out_d = b_out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (accept) begin
      a_sr_d  = bus.a;
      nb_sr_d = ~bus.b;
      // Subtraction as a + ~b + 1 - b_in: initial carry is the inverted borrow.
      carry_d = ~bus.b_in;
      cnt_d   = '0;
      diff_d  = '0;
      ovf_d   = 1'b0;
      zero_d  = 1'b0;
      a_msb_d = bus.a[WIDTH-1];
      b_msb_d = bus.b[WIDTH-1];
    end else if (state_q == S_RUN) begin
      a_sr_d  = a_sr_q >> 1;
      nb_sr_d = nb_sr_q >> 1;
      carry_d = fa_cout;
      diff_d  = {fa_sum, diff_q[WIDTH-1:1]};
      cnt_d   = cnt_q + CNT_W'(1);
      // Flags are captured from the final step so they are valid with done.
      if (last_step) begin
        b_out_d = ~fa_cout;
        ovf_d   = (a_msb_q != b_msb_q) && (fa_sum != a_msb_q);
        zero_d  = (diff_d == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_q  <= '0;
      nb_sr_q <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      b_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      a_sr_q  <= a_sr_d;
      nb_sr_q <= nb_sr_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      b_out_q <= b_out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.diff  = diff_q;
  assign bus.b_out = b_out_q;
  assign bus.ovf   = ovf_q;
  assign bus.zero  = zero_q;

endmodule

// File: tb/tb_serial_sub_4b.sv
// Self-checking bench for serial_sub_4b: directed cases plus random operands
// checked against an arithmetic reference model.
module tb_serial_sub_4b;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_sub_4b_if #(.WIDTH(W)) bus ();

  serial_sub_4b #(
    .WIDTH (W),
    .CNT_W (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference results from plain integer arithmetic.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       output logic [W-1:0] d, output logic bo, output logic ov,
                       output logic z);
    int ia, ib, sa, sb, r;
    ia = int'(a);
    ib = int'(b);
    sa = (ia >= (1 << (W - 1))) ? ia - (1 << W) : ia;
    sb = (ib >= (1 << (W - 1))) ? ib - (1 << W) : ib;
    r  = sa - sb - int'(bin);
    d  = W'(ia - ib - int'(bin));
    bo = (ia < ib + int'(bin));
    ov = (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
    z  = (d == '0);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic bin);
    logic [W-1:0] d;
    logic bo, ov, z;
    model(a, b, bin, d, bo, ov, z);
    check({tag, ".diff"}, 32'(bus.diff), 32'(d));
    check({tag, ".b_out"}, 32'(bus.b_out), 32'(bo));
    check({tag, ".ovf"}, 32'(bus.ovf), 32'(ov));
    check({tag, ".zero"}, 32'(bus.zero), 32'(z));
  endtask

  // Issue one operation from the current cycle and follow it to done.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin);
    int lat;
    int busy_cnt;
    int both;
    lat      = 0;
    busy_cnt = 0;
    both     = 0;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.b_in  = bin;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      next_cycle();
      if (i == 1) bus.start = 1'b0;
      if (bus.busy && bus.done) both++;
      if (bus.busy) busy_cnt++;
      if (bus.done) lat = i;
    end
    check({tag, ".latency"}, 32'(lat), 32'(W + 1));
    check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(W));
    check({tag, ".busy_and_done"}, 32'(both), 32'd0);
    check_result(tag, a, b, bin);
    next_cycle();
    check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
    check_result({tag, ".hold"}, a, b, bin);
  endtask

  initial begin
    int seen_done;
    logic [W-1:0] ra, rb;
    logic rbin;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.b_in  = 1'b0;
    next_cycle();
    next_cycle();
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.done", 32'(bus.done), 32'd0);
    check("reset.diff", 32'(bus.diff), 32'd0);
    check("reset.b_out", 32'(bus.b_out), 32'd0);
    check("reset.ovf", 32'(bus.ovf), 32'd0);
    check("reset.zero", 32'(bus.zero), 32'd0);
    rst = 1'b0;
    next_cycle();

    // Directed cases with known constants
    run_op("9-3", 4'd9, 4'd3, 1'b0);
    run_op("3-9", 4'd3, 4'd9, 1'b0);
    check("3-9.const", 32'(bus.diff), 32'hA);
    run_op("0-0-1", 4'd0, 4'd0, 1'b1);
    check("0-0-1.const", 32'(bus.diff), 32'hF);
    run_op("5-5", 4'd5, 4'd5, 1'b0);
    check("5-5.zero_const", 32'(bus.zero), 32'd1);
    run_op("7-8", 4'h7, 4'h8, 1'b0);
    check("7-8.ovf_const", 32'(bus.ovf), 32'd1);
    run_op("8-1", 4'h8, 4'h1, 1'b0);
    check("8-1.const", 32'(bus.diff), 32'h7);

    // Start re-pulsed mid-run is ignored; then back-to-back from DONE.
    bus.start = 1'b1; bus.a = 4'd9; bus.b = 4'd3; bus.b_in = 1'b0;   // cycle 0
    next_cycle();                                                    // cycle 1
    bus.start = 1'b0;
    next_cycle();                                                    // cycle 2
    bus.start = 1'b1; bus.a = 4'd1; bus.b = 4'd1;
    check("ign.busy_c2", 32'(bus.busy), 32'd1);
    next_cycle();                                                    // cycle 3
    bus.start = 1'b0;
    next_cycle();                                                    // cycle 4
    check("ign.busy_c4", 32'(bus.busy), 32'd1);
    next_cycle();                                                    // cycle 5
    check("ign.done_c5", 32'(bus.done), 32'd1);
    check("ign.diff_c5", 32'(bus.diff), 32'h6);
    bus.start = 1'b1; bus.a = 4'd2; bus.b = 4'd1;                    // held in DONE
    for (int c = 6; c <= 9; c++) begin
      next_cycle();
      if (c == 6) bus.start = 1'b0;
      check($sformatf("b2b.busy_c%0d", c), 32'(bus.busy), 32'd1);
    end
    next_cycle();                                                    // cycle 10
    check("b2b.done_c10", 32'(bus.done), 32'd1);
    check("b2b.diff_c10", 32'(bus.diff), 32'h1);
    next_cycle();

    // Reset mid-run aborts with no done pulse.
    bus.start = 1'b1; bus.a = 4'd9; bus.b = 4'd3; bus.b_in = 1'b0;   // cycle 0
    next_cycle();
    bus.start = 1'b0;
    next_cycle();
    next_cycle();                                                    // cycle 3
    rst = 1'b1;
    next_cycle();                                                    // cycle 4
    rst = 1'b0;
    check("rst_mid.busy", 32'(bus.busy), 32'd0);
    check("rst_mid.done", 32'(bus.done), 32'd0);
    check("rst_mid.diff", 32'(bus.diff), 32'd0);
    check("rst_mid.b_out", 32'(bus.b_out), 32'd0);
    check("rst_mid.ovf", 32'(bus.ovf), 32'd0);
    check("rst_mid.zero", 32'(bus.zero), 32'd0);
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      if (bus.done || bus.busy) seen_done++;
    end
    check("rst_mid.no_done", 32'(seen_done), 32'd0);
    run_op("after_rst", 4'd12, 4'd5, 1'b1);

    // Random operands
    for (int k = 0; k < 40; k++) begin
      ra   = W'($urandom_range(0, (1 << W) - 1));
      rb   = W'($urandom_range(0, (1 << W) - 1));
      rbin = 1'($urandom_range(0, 1));
      run_op($sformatf("rnd%0d", k), ra, rb, rbin);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
